// File: rtl/vga_pixel_compositor.sv
// vga_pixel_compositor: VGA ROM address generation and BCD digit overlay compositing
module vga_pixel_compositor #(
  parameter int         IfaceWidth  = 640,
  parameter int         IfaceHeight = 480,
  parameter int         DigitW      = 40,
  parameter int         DigitH      = 60,
  parameter int         NumFields   = 6,
  parameter int         FieldX0     = 176,
  parameter int         FieldY0     = 210,
  parameter int         FieldPitch  = 48,
  parameter logic [5:0] KeyColor    = 6'b000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  PixelX,
  input  logic [9:0]  PixelY,
  input  logic        VideoOn,
  input  logic        HSyncIn,
  input  logic        VSyncIn,
  input  logic [23:0] DigitsBCD,
  output logic [18:0] AddrInterfaz,
  output logic [14:0] AddrNumeros,
  input  logic [5:0]  DataInterfaz,
  input  logic [5:0]  DataNumeros,
  output logic [5:0]  RGB,
  output logic        HSyncOut,
  output logic        VSyncOut
);
  localparam logic [9:0] Y_TOP = 10'(FieldY0);
  localparam logic [9:0] Y_END = 10'(FieldY0 + DigitH);
  logic [23:0] shadow_q, shadow_d;
  logic [18:0] addr_i_q, addr_i_d;
  logic [14:0] addr_n_q, addr_n_d, row_n;
  logic        hit1_q, hit2_q, von1_q, von2_q;
  logic        hs1_q, hs2_q, hs3_q, vs1_q, vs2_q, vs3_q;
  logic [5:0]  rgb_q, rgb_d;
  logic        hit_x, hit, in_bg, in_y;
  logic [2:0]  fidx;
  logic [9:0]  lx, ly;
  logic [3:0]  digit;
  always_comb begin
    hit_x = 1'b0;
    fidx  = '0;
    lx    = '0;
    for (int i = 0; i < NumFields; i++)
      if (PixelX >= 10'(FieldX0 + i * FieldPitch) && PixelX < 10'(FieldX0 + i * FieldPitch + DigitW)) begin
        hit_x = 1'b1;
        fidx  = 3'(i);
        lx    = PixelX - 10'(FieldX0 + i * FieldPitch);
      end
  end
  // The held copy feeds the lookup so a frame never mixes old and new digits
  assign shadow_d = (VideoOn && PixelX == '0 && PixelY == '0) ? DigitsBCD : shadow_q;
  assign digit    = shadow_q[4*fidx +: 4];
  assign ly       = PixelY - Y_TOP;
  assign in_y     = PixelY >= Y_TOP && PixelY < Y_END;
  assign hit      = in_y && hit_x && digit <= 4'd9;
  assign in_bg    = PixelX < 10'(IfaceWidth) && PixelY < 10'(IfaceHeight);
  assign addr_i_d = in_bg ? 19'(PixelY) * 19'(IfaceWidth) + 19'(PixelX) : '0;
  assign row_n    = 15'(digit) * 15'(DigitH) + 15'(ly);
  assign addr_n_d = hit ? row_n * 15'(DigitW) + 15'(lx) : '0;
  assign rgb_d    = !von2_q ? '0 : (hit2_q && DataNumeros != KeyColor) ? DataNumeros : DataInterfaz;
  always_ff @(posedge CLK)
    if (!RESET) begin
      shadow_q <= '0;
      addr_i_q <= '0;
      addr_n_q <= '0;
      {hit1_q, von1_q, hs1_q, vs1_q} <= '0;
      {hit2_q, von2_q, hs2_q, vs2_q} <= '0;
      {rgb_q, hs3_q, vs3_q} <= '0;
    end else begin
      shadow_q <= shadow_d;
      addr_i_q <= addr_i_d;
      addr_n_q <= addr_n_d;
      {hit1_q, von1_q, hs1_q, vs1_q} <= {hit, VideoOn, HSyncIn, VSyncIn};
      {hit2_q, von2_q, hs2_q, vs2_q} <= {hit1_q, von1_q, hs1_q, vs1_q};
      {rgb_q, hs3_q, vs3_q} <= {rgb_d, hs2_q, vs2_q};
    end
  assign AddrInterfaz = addr_i_q;
  assign AddrNumeros  = addr_n_q;
  assign RGB          = rgb_q;
  assign HSyncOut     = hs3_q;
  assign VSyncOut     = vs3_q;
endmodule

// File: tb/tb_vga_pixel_compositor.sv
// tb_vga_pixel_compositor: randomized and directed checks of the compositor against a pixel-level model
module tb_vga_pixel_compositor;
  logic        CLK = 1'b0, RESET = 1'b0;
  logic [9:0]  PixelX = '0, PixelY = '0;
  logic        VideoOn = 1'b0, HSyncIn = 1'b0, VSyncIn = 1'b0;
  logic [23:0] DigitsBCD = '0;
  logic [18:0] AddrInterfaz;
  logic [14:0] AddrNumeros;
  logic [5:0]  DataInterfaz = '0, DataNumeros = '0, RGB;
  logic        HSyncOut, VSyncOut;
  int          n_checks = 0, n_fail = 0, cyc = 0;
  int          spec_addr = -1;
  logic [5:0]  spec_val = '0;
  logic [23:0] shadow = '0;
  int          exp_ai [8192];
  int          exp_an [8192];
  logic [5:0]  exp_rgb [8192];
  logic        exp_hs [8192];
  logic        exp_vs [8192];

  always #5 CLK = ~CLK;

  vga_pixel_compositor dut (
    .CLK(CLK), .RESET(RESET), .PixelX(PixelX), .PixelY(PixelY), .VideoOn(VideoOn),
    .HSyncIn(HSyncIn), .VSyncIn(VSyncIn), .DigitsBCD(DigitsBCD),
    .AddrInterfaz(AddrInterfaz), .AddrNumeros(AddrNumeros),
    .DataInterfaz(DataInterfaz), .DataNumeros(DataNumeros),
    .RGB(RGB), .HSyncOut(HSyncOut), .VSyncOut(VSyncOut)
  );

  function automatic logic [5:0] bg(input int a);
    return 6'((a * 37 + (a >> 7)) ^ (a >> 3));
  endfunction

  function automatic logic [5:0] glyph(input int a);
    if (a == spec_addr) return spec_val;
    return (a % 5 == 0) ? 6'd0 : 6'((a * 11) ^ (a >> 4));
  endfunction

  // synchronous ROM models: one clock from address to data
  always @(posedge CLK) begin
    DataInterfaz <= bg(int'(AddrInterfaz));
    DataNumeros  <= glyph(int'(AddrNumeros));
  end

  task automatic apply(input int x, input int y, input logic von, input logic hs, input logic vs, input logic rst_n);
    int ai, an, f, lx, ly, d;
    logic hit;
    logic [5:0] rgb;
    PixelX = 10'(x); PixelY = 10'(y); VideoOn = von; HSyncIn = hs; VSyncIn = vs; RESET = rst_n;
    ai = (x < 640 && y < 480) ? y * 640 + x : 0;
    hit = 1'b0; an = 0;
    if (x >= 176 && y >= 210 && y < 270) begin
      f = (x - 176) / 48; lx = (x - 176) % 48; ly = y - 210;
      if (f < 6 && lx < 40) begin
        d = int'((shadow >> (4 * f)) & 24'hF);
        if (d <= 9) begin hit = 1'b1; an = (d * 60 + ly) * 40 + lx; end
      end
    end
    rgb = !von ? 6'd0 : (hit && glyph(an) != 6'd0) ? glyph(an) : bg(ai);
    if (!rst_n) begin
      ai = 0; an = 0; rgb = '0; shadow = '0;
      if (cyc >= 1) begin exp_rgb[cyc-1] = '0; exp_hs[cyc-1] = 1'b0; exp_vs[cyc-1] = 1'b0; end
      if (cyc >= 2) begin exp_rgb[cyc-2] = '0; exp_hs[cyc-2] = 1'b0; exp_vs[cyc-2] = 1'b0; end
    end else if (von && x == 0 && y == 0) shadow = DigitsBCD;
    exp_ai[cyc] = ai; exp_an[cyc] = an; exp_rgb[cyc] = rgb;
    exp_hs[cyc] = rst_n & hs; exp_vs[cyc] = rst_n & vs;
    cyc++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    apply(700, 500, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) apply(181, 217, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({AddrInterfaz, AddrNumeros, RGB, HSyncOut, VSyncOut} !== '0) begin
      n_fail++; $display("FAIL reset_init got ai=%0d an=%0d rgb=%0h hs=%b vs=%b, need all 0", AddrInterfaz, AddrNumeros, RGB, HSyncOut, VSyncOut);
    end
    for (int i = 0; i < 6; i++) apply(200 + i, 220, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(181, 217, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({AddrInterfaz, AddrNumeros, RGB, HSyncOut, VSyncOut} !== '0) begin
        n_fail++; $display("FAIL reset_mid cycle %0d got ai=%0d an=%0d rgb=%0h hs=%b vs=%b, need all 0", i, AddrInterfaz, AddrNumeros, RGB, HSyncOut, VSyncOut);
      end
    end
    apply(5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (AddrInterfaz !== 19'd3205) begin n_fail++; $display("FAIL reset_rel_addr got %0d need 3205", AddrInterfaz); end
    apply(6, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (RGB !== 6'd0 || HSyncOut !== 1'b0) begin n_fail++; $display("FAIL reset_rel_early got rgb=%0h hs=%b need 0 0", RGB, HSyncOut); end
    apply(7, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (RGB !== bg(3205) || HSyncOut !== 1'b1) begin n_fail++; $display("FAIL reset_rel_first got rgb=%0h hs=%b need %0h 1", RGB, HSyncOut, bg(3205)); end
  endtask

  task automatic test_corners();
    apply(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrInterfaz !== 19'd0) begin n_fail++; $display("FAIL corner_addr0 got %0d need 0", AddrInterfaz); end
    apply(639, 479, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrInterfaz !== 19'd307199) begin n_fail++; $display("FAIL corner_addr_max got %0d need 307199", AddrInterfaz); end
    idle();
    n_checks++;
    if (RGB !== bg(0)) begin n_fail++; $display("FAIL corner_rgb0 got %0h need %0h", RGB, bg(0)); end
    idle();
    n_checks++;
    if (RGB !== bg(307199)) begin n_fail++; $display("FAIL corner_rgb_max got %0h need %0h", RGB, bg(307199)); end
  endtask

  task automatic test_overlay();
    DigitsBCD = 24'h000003;
    apply(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    spec_addr = 7485; spec_val = 6'b110000;
    apply(181, 217, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrNumeros !== 15'd7485) begin n_fail++; $display("FAIL overlay_addr got %0d need 7485", AddrNumeros); end
    idle(); idle();
    n_checks++;
    if (RGB !== 6'b110000) begin n_fail++; $display("FAIL overlay_glyph got %0h need 30", RGB); end
    spec_val = 6'b000000;
    apply(181, 217, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    n_checks++;
    if (RGB !== bg(217 * 640 + 181)) begin n_fail++; $display("FAIL overlay_key got %0h need %0h", RGB, bg(217 * 640 + 181)); end
    spec_addr = -1;
  endtask

  task automatic test_gap();
    DigitsBCD = 24'h0000B3;
    apply(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(220, 230, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrNumeros !== 15'd0) begin n_fail++; $display("FAIL gap_addr got %0d need 0", AddrNumeros); end
    apply(225, 230, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrNumeros !== 15'd0) begin n_fail++; $display("FAIL blank_addr got %0d need 0", AddrNumeros); end
    idle();
    n_checks++;
    if (RGB !== bg(230 * 640 + 220)) begin n_fail++; $display("FAIL gap_rgb got %0h need %0h", RGB, bg(230 * 640 + 220)); end
    idle();
    n_checks++;
    if (RGB !== bg(230 * 640 + 225)) begin n_fail++; $display("FAIL blank_rgb got %0h need %0h", RGB, bg(230 * 640 + 225)); end
  endtask

  task automatic test_shadow();
    DigitsBCD = 24'h000001;
    apply(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    DigitsBCD = 24'h000002;
    apply(181, 217, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrNumeros !== 15'd2685) begin n_fail++; $display("FAIL shadow_hold got %0d need 2685", AddrNumeros); end
    apply(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(181, 217, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (AddrNumeros !== 15'd5085) begin n_fail++; $display("FAIL shadow_update got %0d need 5085", AddrNumeros); end
  endtask

  task automatic test_sync();
    for (int i = 0; i < 20; i++) begin
      apply(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b0, 1'($urandom), 1'($urandom), 1'b1);
      n_checks++;
      if (RGB !== exp_rgb[cyc-3] || HSyncOut !== exp_hs[cyc-3] || VSyncOut !== exp_vs[cyc-3]) begin
        n_fail++; $display("FAIL sync cycle %0d got rgb=%0h hs=%b vs=%b need %0h %b %b", i, RGB, HSyncOut, VSyncOut, exp_rgb[cyc-3], exp_hs[cyc-3], exp_vs[cyc-3]);
      end
    end
  endtask

  task automatic test_random();
    int x, y;
    logic von;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin x = int'($urandom_range(170, 470)); y = int'($urandom_range(205, 275)); end
      else begin x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524)); end
      if ($urandom_range(0, 59) == 0) begin x = 0; y = 0; end
      if ($urandom_range(0, 39) == 0) DigitsBCD = 24'($urandom);
      von = (x < 640 && y < 480) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
      apply(x, y, von, 1'($urandom), 1'($urandom), 1'b1);
      n_checks++;
      if (AddrInterfaz !== 19'(exp_ai[cyc-1]) || AddrNumeros !== 15'(exp_an[cyc-1])) begin
        n_fail++; $display("FAIL rnd_addr at x=%0d y=%0d got ai=%0d an=%0d need %0d %0d", x, y, AddrInterfaz, AddrNumeros, exp_ai[cyc-1], exp_an[cyc-1]);
      end
      n_checks++;
      if (RGB !== exp_rgb[cyc-3] || HSyncOut !== exp_hs[cyc-3] || VSyncOut !== exp_vs[cyc-3]) begin
        n_fail++; $display("FAIL rnd_out cycle %0d got rgb=%0h hs=%b vs=%b need %0h %b %b", i, RGB, HSyncOut, VSyncOut, exp_rgb[cyc-3], exp_hs[cyc-3], exp_vs[cyc-3]);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_corners();
    test_overlay();
    test_gap();
    test_shadow();
    test_sync();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pixel_compositor.md
Name: vga_pixel_compositor

Overview:
- Address-generation and compositing stage wrapped around the VGA image ROMs.
- Upstream: converts VGA sync-generator pixel coordinates into the background (Interfaz, 640x480) and digit-strip (Numeros, 40x600, ten stacked 40x60 glyphs) ROM addresses.
- Downstream: consumes the 6-bit ROM words one clock later, overlays up to six numeric digit fields on the background, and emits a registered 6-bit colour word plus delay-matched sync signals to the VGA pins.

Parameters:
- IfaceWidth, 640, background row length in pixels
- IfaceHeight, 480, background rows
- DigitW, 40, glyph width in pixels
- DigitH, 60, glyph height in pixels
- NumFields, 6, number of digit fields
- FieldX0, 176, left x of field 0
- FieldY0, 210, top y of all fields
- FieldPitch, 48, x distance between consecutive field origins
- KeyColor, 6'b000000, glyph pixel value treated as transparent

Ports:
- CLK  in  1  system/pixel clock
- RESET  in  1  synchronous, active-low reset
- PixelX  in  10  current column from sync generator
- PixelY  in  10  current row from sync generator
- VideoOn  in  1  visible-area flag
- HSyncIn  in  1  horizontal sync from sync generator
- VSyncIn  in  1  vertical sync from sync generator
- DigitsBCD  in  24  six BCD digits; field i = DigitsBCD[4i+3:4i]
- AddrInterfaz  out  19  background ROM address
- AddrNumeros  out  15  digit ROM address
- DataInterfaz  in  6  background ROM word, valid 1 clk after address
- DataNumeros  in  6  digit ROM word, valid 1 clk after address
- RGB  out  6  composited colour {R2,G2,B2}
- HSyncOut  out  1  HSyncIn delayed 3 clk
- VSyncOut  out  1  VSyncIn delayed 3 clk

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - clears all pipeline registers, address outputs, RGB, HSyncOut, VSyncOut and the digit shadow register to 0.
  - Reset mid-frame flushes the pipeline; outputs stay 0 until 3 clk after release.
- Digit shadow: DigitsBCD is copied into the shadow register on a clock where VideoOn==1, PixelX==0 and PixelY==0 (frame start). All other cycles use the held copy, so there is no mid-frame tearing.
- Stage 1 (cycle n+1): registers
  - AddrInterfaz = PixelY*IfaceWidth + PixelX (19-bit, no truncation for in-range coordinates);
  - field hit, field index f, local lx = PixelX - (FieldX0 + f*FieldPitch), ly = PixelY - FieldY0;
  - AddrNumeros = (digit_f*DigitH + ly)*DigitW + lx when hit, else 0;
  - VideoOn, syncs.
- Hit conditions: FieldY0 <= PixelY < FieldY0+DigitH, the x position falls inside some field's DigitW span (gaps between fields are not hits), and digit_f <= 9. BCD values 10–15 give no hit (field blank).
- Out-of-range background coordinates (PixelX>=640 or PixelY>=480): AddrInterfaz=0.
- Stage 2 (cycle n+2): ROM words valid; hit, VideoOn and syncs are delayed one more stage.
- Stage 3 (cycle n+3): RGB register:
  - VideoOn==0 -> 0;
  - hit && DataNumeros != KeyColor -> DataNumeros;
  - else -> DataInterfaz.
  - HSyncOut/VSyncOut are aligned to RGB.
- Latency: PixelX/Y to address 1 clk; to RGB 3 clk; fully pipelined, one pixel per clock, no stalls.
- Multiplications use constant parameters (shift/add acceptable); no combinational path from ROM data to address.

Test Plan:
- RESET=0 for 4 clk mid-stream -> RGB, AddrInterfaz, AddrNumeros, HSyncOut, VSyncOut all 0; first valid RGB exactly 3 clk after RESET=1.
- X=0,Y=0 then X=639,Y=479, VideoOn=1 -> AddrInterfaz 0 then 307199 one clk later; RGB equals the ROM-model words 3 clk after each input.
- DigitsBCD field0=3, latched at frame start; X=181,Y=217 -> AddrNumeros=(3*60+7)*40+5=7485; with glyph word 6'b110000 RGB=6'b110000; with glyph word 0 RGB=background word.
- X=220 (gap between field0 and field1), Y=230 -> AddrNumeros=0, RGB=background; field1 value 4'hB, X=225 -> no overlay.
- DigitsBCD changed mid-frame from 0x000001 to 0x000002 -> glyph addresses still use 1 until the next (0,0) frame-start, then use 2.
- Toggle HSyncIn/VSyncIn with VideoOn=0 -> RGB=0, HSyncOut/VSyncOut replicate inputs exactly 3 clk later.
